// File: rtl/fxdiv_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : fxdiv_pkg
// Purpose : Shared helper functions for the shared fixed-point divider slice.
//           clog2/max1 size counters and IDs. fxdiv_lat gives the divider
//           pipeline depth that the tag pipe must match.
// Revision: 1.0 - initial release
// ============================================================================
package fxdiv_pkg;

  // Ceiling log2 for elaboration-time sizing (value <= 2**31).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int value);
    return (value < 1) ? 1 : value;
  endfunction

  // Pipeline latency of pipe_FixedPointDiv for a given quotient format.
  function automatic int fxdiv_lat(input int woi, input int wof);
    return woi + wof + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fxdiv_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface: fxdiv_share_arbiter_if
// Purpose  : Request and result buses of the shared divider arbiter.
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_dividend/divisor  packed signed operands, requester i at [i*W +: W]
//   res_valid/res_ready   result FIFO head handshake
//   res_id/quot/overflow  head result fields
//   busy                  work in flight or results waiting
// Modports : master = requesters and result consumer, slave = arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface fxdiv_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WII  = 8,
  parameter int WIF  = 8,
  parameter int WOI  = 8,
  parameter int WOF  = 8
) ();
  import fxdiv_pkg::*;

  localparam int W   = WII + WIF;
  localparam int WO  = WOI + WOF;
  localparam int IDW = max1(clog2(NREQ));

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_dividend;
  logic [NREQ*W-1:0] req_divisor;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [WO-1:0]     res_quot;
  logic              res_overflow;
  logic              busy;

  modport master (
    output req_valid, req_dividend, req_divisor, res_ready,
    input  req_ready, res_valid, res_id, res_quot, res_overflow, busy
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, res_ready,
    output req_ready, res_valid, res_id, res_quot, res_overflow, busy
  );

endinterface
`default_nettype wire

// File: rtl/fxdiv_share_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_fwft
// Purpose : Synchronous first-word-fall-through FIFO. A word written into an
//           empty FIFO appears on rd_data/valid the following cycle.
//   wr_en/wr_data  write port (ignored when full unless a read frees a slot)
//   rd_en          pop the head (ignored when empty)
//   rd_data/valid  head word and non-empty flag
//   count          occupancy, 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo_fwft
  import fxdiv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         valid,
  output logic [clog2(DEPTH+1)-1:0]    count
);

  localparam int AW = max1(clog2(DEPTH));
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_rd;

  assign w_rd = rd_en && (r_count != '0);
  assign w_wr = wr_en && ((r_count != CW'(DEPTH)) || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_rd) r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign valid   = (r_count != '0);
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_FixedPointDiv.sv
`default_nettype none
// ============================================================================
// Module  : pipe_FixedPointDiv
// Purpose : Signed fixed-point divider, fully pipelined, one operation per
//           cycle, result LAT = WOI+WOF+3 cycles after the operands.
//   dividend/divisor  in  signed WII.WIF
//   out               out signed WOI.WOF quotient, saturated
//   overflow          out saturation flag (also set for a zero divisor)
// Revision: 1.0 - initial release
// ============================================================================
module pipe_FixedPointDiv
  import fxdiv_pkg::*;
#(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WII+WIF-1:0]   dividend,
  input  logic [WII+WIF-1:0]   divisor,
  output logic [WOI+WOF-1:0]   out,
  output logic                 overflow
);

  localparam int W   = WII + WIF;
  localparam int WO  = WOI + WOF;
  localparam int LAT = fxdiv_lat(WOI, WOF);
  localparam int NW  = W + WOF;
  localparam int QW  = NW + 1;

  logic          w_a_neg, w_b_neg, w_neg, w_div0;
  logic [W-1:0]  w_a_mag, w_b_mag;
  logic [NW-1:0] w_num, w_den, w_q, w_r;
  logic [QW-1:0] w_qr, w_lim;
  logic [WO-1:0] w_out;
  logic          w_ovf;

  logic [WO-1:0]  r_out [LAT];
  logic [LAT-1:0] r_ovf;

  // Quotient = |a| * 2^WOF / |b| (WIF cancels); sign applied afterwards.
  always_comb begin
    w_a_neg = dividend[W-1];
    w_b_neg = divisor[W-1];
    w_neg   = w_a_neg ^ w_b_neg;
    w_div0  = (divisor == '0);
    w_a_mag = w_a_neg ? (~dividend + 1'b1) : dividend;
    w_b_mag = w_b_neg ? (~divisor + 1'b1) : divisor;
    w_num   = NW'(w_a_mag) << WOF;
    w_den   = w_div0 ? NW'(1) : NW'(w_b_mag);
    w_q     = w_num / w_den;
    w_r     = w_num % w_den;
    w_qr    = {1'b0, w_q};
    // Round half away from zero on the magnitude.
    if ((ROUND != 0) && ({w_r, 1'b0} >= {1'b0, w_den})) w_qr = w_qr + 1'b1;
    w_lim = w_neg ? (QW'(1) << (WO - 1)) : ((QW'(1) << (WO - 1)) - 1'b1);
    if (w_div0) begin
      w_ovf = 1'b1;
      w_out = w_a_neg ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    end else if (w_qr > w_lim) begin
      w_ovf = 1'b1;
      w_out = w_neg ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    end else begin
      w_ovf = 1'b0;
      w_out = w_neg ? (~w_qr[WO-1:0] + 1'b1) : w_qr[WO-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
      for (int i = 0; i < LAT; i++) r_out[i] <= '0;
    end else begin
      r_out[0] <= w_out;
      r_ovf    <= {r_ovf[LAT-2:0], w_ovf};
      for (int i = 1; i < LAT; i++) r_out[i] <= r_out[i-1];
    end
  end

  assign out      = r_out[LAT-1];
  assign overflow = r_ovf[LAT-1];

endmodule
`default_nettype wire

// File: rtl/fxdiv_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fxdiv_share_arbiter
// Purpose : Shares one pipe_FixedPointDiv among NREQ requesters. Round-robin
//           grant of at most one request per cycle, requester ID carried in
//           a tag pipe matched to the divider latency, results queued in a
//           FWFT FIFO whose space is reserved up front by a credit check so
//           the divider never has to stall.
//   clk, rst  clock and synchronous active-high reset (also resets divider)
//   bus       fxdiv_share_arbiter_if.slave: request and result buses
// Revision: 1.0 - initial release
// ============================================================================
module fxdiv_share_arbiter
  import fxdiv_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1,
  parameter int DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  fxdiv_share_arbiter_if.slave bus
);

  localparam int LAT = fxdiv_lat(WOI, WOF);
  localparam int IDW = max1(clog2(NREQ));
  localparam int W   = WII + WIF;
  localparam int WO  = WOI + WOF;
  localparam int CW  = clog2(DEPTH + 1);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [WO-1:0]  quot;
    logic           overflow;
  } res_entry_t;

  localparam int EW = $bits(res_entry_t);

  logic [IDW-1:0]  r_rr_ptr;
  logic [LAT-1:0]  r_tag_v;
  logic [IDW-1:0]  r_tag_id [LAT];
  logic [CW-1:0]   r_inflight;

  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_valid;
  logic            w_credit_ok;
  logic [NREQ-1:0] w_rot;
  logic            w_found;
  logic [IDW:0]    w_sum;
  logic [IDW-1:0]  w_gidx;
  logic            w_xfer;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_next_ptr;
  logic [W-1:0]    w_dividend, w_divisor;
  logic [WO-1:0]   w_div_out;
  logic            w_div_ovf;
  res_entry_t      w_push_entry, w_head;
  logic [EW-1:0]   w_head_bits;
  logic            w_pop;

  // Every issued operation already owns a FIFO slot, so push never blocks.
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (CW+1)'(DEPTH);

  // Rotate valids so bit k is requester (rr_ptr+k) mod NREQ, then take the
  // lowest set bit and map the offset back to a requester index.
  always_comb begin
    w_rot   = NREQ'({bus.req_valid, bus.req_valid} >> r_rr_ptr);
    w_found = 1'b0;
    w_sum   = {1'b0, r_rr_ptr};
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      end
    end
    if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
    w_gidx     = w_sum[IDW-1:0];
    w_xfer     = w_found && w_credit_ok && !rst;
    w_grant    = w_xfer ? (NREQ'(1) << w_gidx) : '0;
    w_next_ptr = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
  end

  // Granted operands go straight to the divider; idle cycles feed zeros
  // whose results are dropped because their tag is invalid.
  always_comb begin
    w_dividend = '0;
    w_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_dividend = bus.req_dividend[i*W +: W];
        w_divisor  = bus.req_divisor[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_tag_v    <= '0;
      r_inflight <= '0;
      for (int i = 0; i < LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v     <= {r_tag_v[LAT-2:0], w_xfer};
      r_tag_id[0] <= w_gidx;
      for (int i = 1; i < LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
      if (w_xfer) r_rr_ptr <= w_next_ptr;
      // A tag leaving the pipe moves from inflight into the FIFO count.
      case ({w_xfer, r_tag_v[LAT-1]})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  pipe_FixedPointDiv #(
    .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .ROUND(ROUND)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .out      (w_div_out),
    .overflow (w_div_ovf)
  );

  assign w_push_entry = '{id: r_tag_id[LAT-1], quot: w_div_out, overflow: w_div_ovf};
  assign w_pop        = w_fifo_valid && bus.res_ready;

  sync_fifo_fwft #(
    .WIDTH(EW), .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (r_tag_v[LAT-1]),
    .wr_data (w_push_entry),
    .rd_en   (w_pop),
    .rd_data (w_head_bits),
    .valid   (w_fifo_valid),
    .count   (w_fifo_count)
  );

  assign w_head           = res_entry_t'(w_head_bits);
  assign bus.req_ready    = w_grant;
  assign bus.res_valid    = w_fifo_valid;
  assign bus.res_id       = w_head.id;
  assign bus.res_quot     = w_head.quot;
  assign bus.res_overflow = w_head.overflow;
  assign bus.busy         = (r_inflight != '0) || w_fifo_valid;

endmodule
`default_nettype wire

// File: tb/tb_fxdiv_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fxdiv_share_arbiter
// Purpose : Self-checking bench for fxdiv_share_arbiter (NREQ=4, Q8.8, DEPTH=32)
// Revision: 1.0 - initial release
// ============================================================================
module tb_fxdiv_share_arbiter;
  localparam int NREQ = 4, WII = 8, WIF = 8, WOI = 8, WOF = 8, ROUND = 1, DEPTH = 32;
  localparam int LAT = WOI + WOF + 3;
  localparam int W = WII + WIF;

  typedef struct packed { logic [1:0] id; logic [15:0] q; logic ovf; } exp_t;
  typedef struct { int id; logic [15:0] a; logic [15:0] b; logic [15:0] q; logic ovf; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fxdiv_share_arbiter_if #(.NREQ(NREQ), .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF)) bus ();

  fxdiv_share_arbiter #(
    .NREQ(NREQ), .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .ROUND(ROUND), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   auto_push = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: real-valued quotient, round half away from zero.
  function automatic exp_t model(input int id, input logic [15:0] a, input logic [15:0] b);
    real  r;
    int   qi;
    exp_t e;
    e.id = 2'(id);
    if (b == 16'h0) begin
      e.ovf = 1'b1;
      e.q   = a[15] ? 16'h8000 : 16'h7FFF;
      return e;
    end
    r  = $itor($signed(a)) * 256.0 / $itor($signed(b));
    qi = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    if (qi > 32767)       begin e.ovf = 1'b1; e.q = 16'h7FFF; end
    else if (qi < -32768) begin e.ovf = 1'b1; e.q = 16'h8000; end
    else                  begin e.ovf = 1'b0; e.q = 16'(qi);  end
    return e;
  endfunction

  // Monitor: log grants, push model results for transfers, pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("req_ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          grant_log.push_back(i);
          if (auto_push)
            sb.push_back(model(i, bus.req_dividend[i*W +: W], bus.req_divisor[i*W +: W]));
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", {13'd0, bus.res_id, bus.res_quot, bus.res_overflow}, 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check("result", {13'd0, bus.res_id, bus.res_quot, bus.res_overflow}, {13'd0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_dividend[i*W +: W] = a;
    bus.req_divisor[i*W +: W]  = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++)
      set_op(i, 16'($urandom), ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom));
  endtask

  task automatic drain(input int limit);
    bus.res_ready = 1'b1;
    for (int t = 0; t < limit; t++) begin
      if (!bus.busy && sb.size() == 0) return;
      tick();
    end
    check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int   issue_cyc, got, bad, viol, g0;
    tbl[0] = '{1, 16'h0600, 16'h0200, 16'h0300, 1'b0};  //  6.0 / 2.0
    tbl[1] = '{0, 16'hF880, 16'h0280, 16'hFD00, 1'b0};  // -7.5 / 2.5
    tbl[2] = '{0, 16'h0100, 16'h0000, 16'h7FFF, 1'b1};  //  1.0 / 0
    tbl[3] = '{2, 16'h0100, 16'h0300, 16'h0055, 1'b0};  //  1/3 rounds down
    tbl[4] = '{3, 16'h7F00, 16'h0080, 16'h7FFF, 1'b1};  //  127 / 0.5 saturates
    tbl[5] = '{1, 16'h8000, 16'h0100, 16'h8000, 1'b0};  // -128 / 1 exactly fits
    tbl[6] = '{2, 16'h0200, 16'hFF00, 16'hFE00, 1'b0};  //  2 / -1
    tbl[7] = '{3, 16'h0001, 16'h0200, 16'h0001, 1'b0};  //  half LSB rounds up
    tbl[8] = '{0, 16'hFF00, 16'h0000, 16'h8000, 1'b1};  // -1 / 0

    bus.req_valid = '0; bus.req_dividend = '0; bus.req_divisor = '0; bus.res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_res_valid", 32'(bus.res_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    tick();

    // Single issues from the table, one at a time, with latency check.
    foreach (tbl[v]) begin
      sb.push_back(exp_t'{2'(tbl[v].id), tbl[v].q, tbl[v].ovf});
      set_op(tbl[v].id, tbl[v].a, tbl[v].b);
      bus.req_valid = '0;
      bus.req_valid[tbl[v].id] = 1'b1;
      bus.res_ready = 1'b1;
      issue_cyc = -1;
      for (int t = 0; t < 10 && issue_cyc < 0; t++) begin
        @(negedge clk);
        if (bus.req_ready[tbl[v].id]) issue_cyc = cyc;
        tick();
      end
      bus.req_valid = '0;
      check("grant_seen", 32'(issue_cyc >= 0), 32'd1);
      got = -1;
      for (int t = 0; t < LAT + 10 && got < 0; t++) begin
        @(negedge clk);
        if (bus.res_valid) got = cyc;
      end
      check("latency", 32'(got - issue_cyc), 32'(LAT + 1));
      drain(50);
    end

    // Full throughput: all requesters valid, consumer always ready.
    auto_push = 1'b1;
    grant_log.delete();
    bus.res_ready = 1'b1;
    rand_ops();
    bus.req_valid = '1;
    repeat (40) begin tick(); rand_ops(); end
    bus.req_valid = '0;
    check("throughput_grants", 32'(grant_log.size()), 32'd40);
    g0 = grant_log[0];
    check("rr_first_after_table", 32'(g0), 32'd1);
    bad = 0;
    foreach (grant_log[k]) if (grant_log[k] != (g0 + k) % NREQ) bad++;
    check("rr_order", 32'(bad), 32'd0);
    drain(200);

    // Credit limit: consumer stalled, exactly DEPTH grants, then one per pop.
    grant_log.delete();
    bus.res_ready = 1'b0;
    rand_ops();
    bus.req_valid = '1;
    repeat (60) begin tick(); rand_ops(); end
    check("credit_grants", 32'(grant_log.size()), 32'(DEPTH));
    @(negedge clk);
    check("credit_ready_low", 32'(bus.req_ready), 32'd0);
    tick();
    grant_log.delete();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    repeat (6) tick();
    check("credit_one_pop_one_grant", 32'(grant_log.size()), 32'd1);
    bus.req_valid = '0;
    drain(200);

    // Reset with work in flight and results waiting in the FIFO.
    bus.res_ready = 1'b0;
    rand_ops();
    bus.req_valid = '1;
    repeat (11) begin tick(); rand_ops(); end
    bus.req_valid = '0;
    got = 0;
    for (int t = 0; t < LAT + 10 && got == 0; t++) begin
      @(negedge clk);
      if (bus.res_valid) got = 1;
    end
    check("pre_reset_result_waiting", 32'(got), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_reset_res_valid", 32'(bus.res_valid), 32'd0);
    check("mid_reset_busy", 32'(bus.busy), 32'd0);
    bus.res_ready = 1'b1;
    viol = 0;
    for (int t = 0; t < LAT + 5; t++) begin
      @(negedge clk);
      if (bus.res_valid || bus.busy) viol++;
    end
    check("post_reset_silent", 32'(viol), 32'd0);
    tick();
    bus.req_valid = '1;
    #1;
    check("post_reset_rr_zero", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    tick();

    // Round-robin skip and hold with requesters 0 and 2.
    grant_log.delete();
    set_op(0, 16'h0A00, 16'h0200);
    set_op(2, 16'hF600, 16'h0300);
    bus.req_valid = 4'b0001;
    #1;
    check("rr_setup_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0101;
    #1;
    check("rr_skip_to_2", 32'(bus.req_ready), 32'h4);
    bus.req_valid = 4'b0000;
    #1;
    check("rr_drop_no_grant", 32'(bus.req_ready), 32'h0);
    tick();
    bus.req_valid = 4'b0101;
    #1;
    check("rr_hold_2", 32'(bus.req_ready), 32'h4);
    tick();
    check("rr_then_0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    check("rr_transfers", 32'(grant_log.size()), 32'd3);
    drain(100);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
